// File: rtl/fetch_unit.sv
// Instruction-fetch stage with imem request/ack handshake and the F/D pipeline register.
// Optional macro FETCH_ALIGN_CHECK_EN adds misaligned-fetch detection (adel_D).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        PC_sel,
  input  logic [1:0]  b_j_jr_sel,
  input  logic [31:0] RS_D,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IR_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC8_D,
  output logic        fetch_stall
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        adel_D
`endif
);

  typedef enum logic {
    F_REQ  = 1'b0,
    F_HAVE = 1'b1
  } fstate_t;

  fstate_t     r_state;
  fstate_t     w_state_next;
  logic [31:0] r_pc_f;
  logic [31:0] r_ir_f;
  logic [31:0] r_ir_d;
  logic [31:0] r_pc_d;

  logic        w_misalign;
  logic        w_f_valid;
  logic        w_d_fire;
  logic        w_capture;
  logic        w_req;
  logic [31:0] w_word;
  logic [31:0] w_npc;
  logic [31:0] w_br_target;
  logic [31:0] w_j_target;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_adel_d;
  assign w_misalign = (r_pc_f[1:0] != 2'b00);
  assign adel_D     = r_adel_d;
`else
  assign w_misalign = 1'b0;
`endif

  // Handshake: the acked word bypasses straight into D unless stalled, then it is buffered.
  always_comb begin
    w_f_valid    = 1'b0;
    w_word       = r_ir_f;
    w_req        = 1'b0;
    w_capture    = 1'b0;
    w_state_next = r_state;
    case (r_state)
      F_REQ: begin
        if (w_misalign) begin
          w_f_valid = 1'b1;
          w_word    = 32'h0000_0000;
        end else begin
          w_req     = 1'b1;
          w_f_valid = imem_ack;
          w_word    = imem_rdata;
          w_capture = imem_ack & stall;
        end
      end
      F_HAVE: begin
        w_f_valid = 1'b1;
        w_word    = r_ir_f;
      end
      default: begin
        w_f_valid = 1'b0;
      end
    endcase
    w_d_fire = w_f_valid & ~stall;
    if (w_d_fire) begin
      w_state_next = F_REQ;
    end else if (w_capture) begin
      w_state_next = F_HAVE;
    end
  end

  // Redirect targets are computed from the branch/jump sitting in D.
  assign w_br_target = r_pc_d + 32'd4 + {{14{r_ir_d[15]}}, r_ir_d[15:0], 2'b00};
  assign w_j_target  = {r_pc_d[31:28], r_ir_d[25:0], 2'b00};

  always_comb begin
    w_npc = r_pc_f + 32'd4;
    if (PC_sel) begin
      case (b_j_jr_sel)
        2'd1:    w_npc = w_j_target;
        2'd2:    w_npc = RS_D;
        default: w_npc = w_br_target;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= F_REQ;
      r_pc_f  <= RESET_PC;
      r_ir_f  <= 32'h0000_0000;
      r_ir_d  <= 32'h0000_0000;
      r_pc_d  <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_ir_f <= imem_rdata;
      end
      if (w_d_fire) begin
        r_ir_d <= w_word;
        r_pc_d <= r_pc_f;
        r_pc_f <= w_npc;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_adel_d <= 1'b0;
    end else if (w_d_fire) begin
      r_adel_d <= w_misalign;
    end
  end
`endif

  assign imem_req    = w_req;
  assign imem_addr   = r_pc_f;
  assign IR_D        = r_ir_d;
  assign PC_D        = r_pc_d;
  assign PC8_D       = r_pc_d + 32'd8;
  assign fetch_stall = ~w_f_valid;

endmodule
